// File: rtl/uart_log_arbiter.sv
// AHB-Lite master sharing the UART Tx path among NUM_REQ byte-stream requesters.
// Round-robin arbitration per message, optional timestamp prefix, TXB credit polling.
module uart_log_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter logic [31:0] UART_BASE = 32'h0000_0000,
  parameter bit          TS_PREFIX = 1'b1,
  parameter int unsigned POLL_GAP  = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 busy_o,
  output logic [31:0]          ahbl_haddr_o,
  output logic [1:0]           ahbl_htrans_o,
  output logic                 ahbl_hwrite_o,
  output logic [2:0]           ahbl_hsize_o,
  output logic [2:0]           ahbl_hburst_o,
  output logic [31:0]          ahbl_hwdata_o,
  input  logic                 ahbl_hready_i,
  input  logic [31:0]          ahbl_hrdata_i,
  input  logic                 ahbl_hresp_i
);

  localparam int unsigned IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [31:0] AddrThr = UART_BASE;
  localparam logic [31:0] AddrTxb = UART_BASE + 32'h18;
  localparam logic [31:0] AddrTms = UART_BASE + 32'h2C;
  localparam logic [15:0] TsBytes = 16'd10;
  localparam logic [15:0] GapLast = 16'(POLL_GAP - 1);
  localparam logic [1:0]  HtIdle  = 2'b00;
  localparam logic [1:0]  HtNseq  = 2'b10;

  typedef enum logic [3:0] {
    StIdle, StArb, StTs, StTsData, StChk, StPoll, StPollData, StGap, StWr, StWrAddr, StWrData
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        credit_q, credit_d;
  logic [15:0]        gap_q, gap_d;
  logic [IdxW-1:0]    owner_q, owner_d;
  logic [IdxW-1:0]    rr_q, rr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               ts_pend_q, ts_pend_d;
  logic [7:0]         byte_q, byte_d;
  logic               last_q, last_d;

  logic [IdxW-1:0]    pick, cand;
  logic               pick_vld;
  logic [15:0]        rd_credit;
  logic               unused_sig;

  assign rd_credit     = ahbl_hrdata_i[15:0];
  assign unused_sig    = ahbl_hresp_i ^ (^ahbl_hrdata_i[31:16]);
  assign ahbl_hsize_o  = 3'b010;
  assign ahbl_hburst_o = 3'b000;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != StIdle);

  // First valid requester at or after the round-robin pointer, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_q) + i >= NUM_REQ) ? IdxW'(32'(rr_q) + i - NUM_REQ) : IdxW'(32'(rr_q) + i);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    gap_d         = gap_q;
    owner_d       = owner_q;
    rr_d          = rr_q;
    grant_d       = grant_q;
    ts_pend_d     = ts_pend_q;
    byte_d        = byte_q;
    last_d        = last_q;
    req_ready_o   = '0;
    ahbl_htrans_o = HtIdle;
    ahbl_haddr_o  = '0;
    ahbl_hwrite_o = 1'b0;
    ahbl_hwdata_o = '0;
    case (state_q)
      StIdle: if (|req_valid_i) state_d = StArb;
      StArb: begin
        if (pick_vld) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          ts_pend_d     = TS_PREFIX;
          state_d       = TS_PREFIX ? StTs : StChk;
        end else begin
          state_d = StIdle;
        end
      end
      StTs: begin
        if (credit_q < TsBytes) begin
          state_d = StPoll;
        end else begin
          ahbl_htrans_o = HtNseq;
          ahbl_haddr_o  = AddrTms;
          ahbl_hwrite_o = 1'b1;
          if (ahbl_hready_i) state_d = StTsData;
        end
      end
      StTsData: begin
        ahbl_hwdata_o = 32'd1;
        if (ahbl_hready_i) begin
          // TXB stays at 0 until the UART has queued the timestamp bytes.
          credit_d  = '0;
          ts_pend_d = 1'b0;
          state_d   = StPoll;
        end
      end
      StChk: begin
        if (credit_q == '0) state_d = StPoll;
        else if (req_valid_i[owner_q]) state_d = StWr;
      end
      StPoll: begin
        ahbl_htrans_o = HtNseq;
        ahbl_haddr_o  = AddrTxb;
        if (ahbl_hready_i) state_d = StPollData;
      end
      StPollData: begin
        if (ahbl_hready_i) begin
          credit_d = rd_credit;
          gap_d    = '0;
          if (rd_credit == '0 || (ts_pend_q && rd_credit < TsBytes)) state_d = StGap;
          else state_d = ts_pend_q ? StTs : StChk;
        end
      end
      StGap: begin
        if (gap_q >= GapLast) state_d = StPoll;
        else gap_d = gap_q + 16'd1;
      end
      StWr: begin
        // Byte is consumed here, even if the address phase has to be held.
        req_ready_o[owner_q] = 1'b1;
        byte_d        = req_data_i[{owner_q, 3'b000} +: 8];
        last_d        = req_last_i[owner_q];
        credit_d      = credit_q - 16'd1;
        ahbl_htrans_o = HtNseq;
        ahbl_haddr_o  = AddrThr;
        ahbl_hwrite_o = 1'b1;
        state_d       = ahbl_hready_i ? StWrData : StWrAddr;
      end
      StWrAddr: begin
        ahbl_htrans_o = HtNseq;
        ahbl_haddr_o  = AddrThr;
        ahbl_hwrite_o = 1'b1;
        if (ahbl_hready_i) state_d = StWrData;
      end
      StWrData: begin
        ahbl_hwdata_o = {24'b0, byte_q};
        if (ahbl_hready_i) begin
          if (last_q) begin
            rr_d    = (32'(owner_q) == NUM_REQ - 1) ? '0 : owner_q + 1'b1;
            grant_d = '0;
            state_d = StIdle;
          end else begin
            state_d = StChk;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      credit_q  <= '0;
      gap_q     <= '0;
      owner_q   <= '0;
      rr_q      <= '0;
      grant_q   <= '0;
      ts_pend_q <= 1'b0;
      byte_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      gap_q     <= gap_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      ts_pend_q <= ts_pend_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
    end
  end

endmodule

// File: tb/tb_uart_log_arbiter.sv
// Directed bench for uart_log_arbiter: UART slave models with scripted TXB replies,
// byte-stream requesters, and a transfer log compared against hand-computed sequences.
module tb_uart_log_arbiter;

  localparam int unsigned NR   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam int unsigned GAP  = 8;
  localparam logic [31:0] RD_TXB = 32'h0000_1800;
  localparam logic [31:0] TMS1   = 32'h0001_2C01;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (no timestamp prefix)
  logic [NR-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*NR-1:0] req_data;
  logic            busy, hwrite, hready;
  logic [31:0]     haddr, hwdata, hrdata;
  logic [1:0]      htrans;
  logic [2:0]      hsize, hburst;

  uart_log_arbiter #(
    .NUM_REQ(NR), .UART_BASE(BASE), .TS_PREFIX(1'b0), .POLL_GAP(GAP)
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_last_i(req_last),
    .req_ready_o(req_ready), .grant_o(grant), .busy_o(busy),
    .ahbl_haddr_o(haddr), .ahbl_htrans_o(htrans), .ahbl_hwrite_o(hwrite),
    .ahbl_hsize_o(hsize), .ahbl_hburst_o(hburst), .ahbl_hwdata_o(hwdata),
    .ahbl_hready_i(hready), .ahbl_hrdata_i(hrdata), .ahbl_hresp_i(1'b0)
  );

  // Timestamp-prefix DUT
  logic        tv, tl, t_busy, t_hwrite, t_hready;
  logic [7:0]  td;
  logic [1:0]  t_ready, t_grant, t_htrans;
  logic [31:0] t_haddr, t_hwdata, t_hrdata;
  logic [2:0]  t_hsize, t_hburst;

  uart_log_arbiter #(
    .NUM_REQ(2), .UART_BASE(32'h0), .TS_PREFIX(1'b1), .POLL_GAP(4)
  ) dut_ts (
    .clk(clk), .resetn(resetn),
    .req_valid_i({1'b0, tv}), .req_data_i({8'h00, td}), .req_last_i({1'b0, tl}),
    .req_ready_o(t_ready), .grant_o(t_grant), .busy_o(t_busy),
    .ahbl_haddr_o(t_haddr), .ahbl_htrans_o(t_htrans), .ahbl_hwrite_o(t_hwrite),
    .ahbl_hsize_o(t_hsize), .ahbl_hburst_o(t_hburst), .ahbl_hwdata_o(t_hwdata),
    .ahbl_hready_i(t_hready), .ahbl_hrdata_i(t_hrdata), .ahbl_hresp_i(1'b0)
  );

  // UART slave for the main DUT: hready low one cycle per access, scripted TXB replies
  logic [15:0] s_txb [8];
  int          s_n, s_idx, s_ph, s_cyc;
  logic [31:0] s_addr;
  logic        s_wr;
  logic [31:0] ev_code [64];
  logic [31:0] ev_addr [64];
  logic [31:0] ev_data [64];
  int          ev_cyc  [64];
  int          ev_n;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hready <= 1'b1; hrdata <= '0; s_ph <= 0; s_idx <= 0; ev_n <= 0;
    end else if (s_ph == 1) begin
      hready <= 1'b1;
      s_ph   <= 2;
      if (!s_wr && s_addr == BASE + 32'h18) begin
        hrdata <= (s_idx < s_n) ? {16'h0, s_txb[s_idx]} : 32'd1024;
        s_idx  <= s_idx + 1;
      end else begin
        hrdata <= '0;
      end
    end else if (s_ph == 2) begin
      s_ph <= 0;
      if (ev_n < 64) begin
        ev_code[ev_n] <= {15'b0, s_wr, s_addr[7:0], s_wr ? hwdata[7:0] : 8'h00};
        ev_addr[ev_n] <= s_addr;
        ev_data[ev_n] <= s_wr ? hwdata : 32'h0;
        ev_cyc[ev_n]  <= s_cyc;
        ev_n          <= ev_n + 1;
      end
    end else if (htrans == 2'b10) begin
      s_addr <= haddr; s_wr <= hwrite; s_cyc <= cyc; hready <= 1'b0; s_ph <= 1;
    end
  end

  // UART slave for the timestamp DUT
  logic [15:0] s2_txb [8];
  int          s2_n, s2_idx, s2_ph;
  logic [31:0] s2_addr;
  logic        s2_wr;
  logic [31:0] ev2_code [64];
  logic [31:0] ev2_data [64];
  int          ev2_n;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      t_hready <= 1'b1; t_hrdata <= '0; s2_ph <= 0; s2_idx <= 0; ev2_n <= 0;
    end else if (s2_ph == 1) begin
      t_hready <= 1'b1;
      s2_ph    <= 2;
      if (!s2_wr && s2_addr == 32'h18) begin
        t_hrdata <= (s2_idx < s2_n) ? {16'h0, s2_txb[s2_idx]} : 32'd1024;
        s2_idx   <= s2_idx + 1;
      end else begin
        t_hrdata <= '0;
      end
    end else if (s2_ph == 2) begin
      s2_ph <= 0;
      if (ev2_n < 64) begin
        ev2_code[ev2_n] <= {15'b0, s2_wr, s2_addr[7:0], s2_wr ? t_hwdata[7:0] : 8'h00};
        ev2_data[ev2_n] <= s2_wr ? t_hwdata : 32'h0;
        ev2_n           <= ev2_n + 1;
      end
    end else if (t_htrans == 2'b10) begin
      s2_addr <= t_haddr; s2_wr <= t_hwrite; t_hready <= 1'b0; s2_ph <= 1;
    end
  end

  // Requesters: per-requester byte queues {last, byte}; optional stall after next pop
  logic [8:0] rq_mem [NR][16];
  int         rq_head [NR];
  int         rq_tail [NR];
  int         rq_stall [NR];
  int         rq_arm [NR];
  logic [NR-1:0] took;

  always begin
    @(negedge clk);
    took = req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (took[i] && rq_head[i] < rq_tail[i]) begin
        rq_head[i]++;
        if (rq_arm[i] > 0) begin
          rq_stall[i] = rq_arm[i];
          rq_arm[i]   = 0;
        end
      end else if (rq_stall[i] > 0) begin
        rq_stall[i]--;
      end
      req_valid[i] = (rq_head[i] < rq_tail[i]) && (rq_stall[i] == 0);
      {req_last[i], req_data[8*i +: 8]} = (rq_head[i] < rq_tail[i]) ? rq_mem[i][rq_head[i]] : 9'h0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] thr(input logic [7:0] b);
    return {15'b0, 1'b1, 8'h00, b};
  endfunction

  task automatic push(input int r, input logic [7:0] b, input logic l);
    rq_mem[r][rq_tail[r]] = {l, b};
    rq_tail[r]++;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0; rq_tail[i] = 0; rq_stall[i] = 0; rq_arm[i] = 0;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_reqs();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int n);
    int k = 0;
    while (k < 5000 && !(ev_n >= n && !busy)) begin
      @(negedge clk);
      k++;
    end
    check_eq({tag, "_nev"}, ev_n, n);
    check_eq({tag, "_idle"}, {31'b0, busy}, 32'h0);
  endtask

  initial begin
    int k;
    logic [7:0] b;
    logic [NR-1:0] seen;
    clear_reqs();
    req_valid = '0; req_last = '0; req_data = '0;
    tv = 1'b0; tl = 1'b0; td = 8'h00;
    s_n = 0; s2_n = 0;
    for (int i = 0; i < 8; i++) begin
      s_txb[i] = 16'h0; s2_txb[i] = 16'h0;
    end

    // Reset values
    #1;
    check_eq("rst_haddr", haddr, 32'h0);
    check_eq("rst_hwdata", hwdata, 32'h0);
    check_eq("rst_ctl", {21'b0, htrans, hwrite, busy, grant, req_ready}, 32'h0);
    check_eq("rst_const", {26'b0, hsize, hburst}, 32'b010_000);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);

    // 1) Single message "AB"
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b1);
    k = 0;
    while (k < 500 && req_ready == '0) begin
      @(negedge clk);
      k++;
    end
    check_eq("t1_ready", {28'b0, req_ready}, 32'h1);
    check_eq("t1_grant", {28'b0, grant}, 32'h1);
    wait_done("t1", 3);
    check_eq("t1_poll", ev_code[0], RD_TXB);
    check_eq("t1_txb_addr", ev_addr[0], BASE + 32'h18);
    check_eq("t1_wr0", ev_code[1], thr(8'h41));
    check_eq("t1_thr_addr", ev_addr[1], BASE);
    check_eq("t1_wdata0", ev_data[1], 32'h41);
    check_eq("t1_wr1", ev_code[2], thr(8'h42));
    check_eq("t1_grant_end", {28'b0, grant}, 32'h0);

    // 2) Contention, two rounds
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int j = 0; j < 3; j++) begin
          b = 8'((r * 128) + (i * 16) + j);
          push(i, b, j == 2);
        end
    wait_done("t2", 25);
    check_eq("t2_poll", ev_code[0], RD_TXB);
    k = 1;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++)
        for (int j = 0; j < 3; j++) begin
          b = 8'((r * 128) + (i * 16) + j);
          check_eq($sformatf("t2_ev%0d", k), ev_code[k], thr(b));
          k++;
        end

    // 3) Backpressure: TXB 2, 0, 0, 5
    s_txb[0] = 16'd2; s_txb[1] = 16'd0; s_txb[2] = 16'd0; s_txb[3] = 16'd5;
    s_n = 4;
    do_reset();
    for (int j = 0; j < 4; j++) push(0, 8'h30 + 8'(j), j == 3);
    wait_done("t3", 8);
    check_eq("t3_ev0", ev_code[0], RD_TXB);
    check_eq("t3_ev1", ev_code[1], thr(8'h30));
    check_eq("t3_ev2", ev_code[2], thr(8'h31));
    check_eq("t3_ev3", ev_code[3], RD_TXB);
    check_eq("t3_ev4", ev_code[4], RD_TXB);
    check_eq("t3_ev5", ev_code[5], RD_TXB);
    check_eq("t3_ev6", ev_code[6], thr(8'h32));
    check_eq("t3_ev7", ev_code[7], thr(8'h33));
    check_eq("t3_gap1", ev_cyc[4] - ev_cyc[3], GAP + 3);
    check_eq("t3_gap2", ev_cyc[5] - ev_cyc[4], GAP + 3);
    s_n = 0;

    // 4) Timestamp prefix: TXB 1024, then 0, 0, 3 after the TMS write
    s2_txb[0] = 16'd1024; s2_txb[1] = 16'd0; s2_txb[2] = 16'd0; s2_txb[3] = 16'd3;
    s2_n = 4;
    do_reset();
    tv = 1'b1; td = 8'h5A; tl = 1'b1;
    k = 0;
    while (k < 1000 && t_ready == 2'b00) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_ready", {30'b0, t_ready}, 32'h1);
    @(posedge clk);
    #1 tv = 1'b0;
    k = 0;
    while (k < 1000 && !(ev2_n >= 6 && !t_busy)) begin
      @(negedge clk);
      k++;
    end
    check_eq("t4_nev", ev2_n, 6);
    check_eq("t4_ev0", ev2_code[0], RD_TXB);
    check_eq("t4_ev1", ev2_code[1], TMS1);
    check_eq("t4_tms_wdata", ev2_data[1], 32'h1);
    check_eq("t4_ev2", ev2_code[2], RD_TXB);
    check_eq("t4_ev3", ev2_code[3], RD_TXB);
    check_eq("t4_ev4", ev2_code[4], RD_TXB);
    check_eq("t4_ev5", ev2_code[5], thr(8'h5A));
    s2_n = 0;

    // 5) Owner stalls mid-message while req1 waits
    do_reset();
    rq_arm[0] = 50;
    push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b1);
    push(1, 8'h60, 1'b0); push(1, 8'h61, 1'b1);
    k = 0;
    while (k < 1000 && ev_n < 2) begin
      @(negedge clk);
      k++;
    end
    seen = '0;
    repeat (20) begin
      @(negedge clk);
      seen |= req_ready;
    end
    check_eq("t5_grant_held", {28'b0, grant}, 32'h1);
    check_eq("t5_no_ready", {28'b0, seen}, 32'h0);
    wait_done("t5", 6);
    check_eq("t5_ev0", ev_code[0], RD_TXB);
    check_eq("t5_ev1", ev_code[1], thr(8'h50));
    check_eq("t5_ev2", ev_code[2], thr(8'h51));
    check_eq("t5_ev3", ev_code[3], thr(8'h52));
    check_eq("t5_ev4", ev_code[4], thr(8'h60));
    check_eq("t5_ev5", ev_code[5], thr(8'h61));
    check_eq("t5_stall", {31'b0, (ev_cyc[2] - ev_cyc[1]) >= 50}, 32'h1);

    // 6) Reset during a THR data phase
    do_reset();
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b1);
    k = 0;
    while (k < 500 && hwdata != 32'h70) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_dphase", hwdata, 32'h70);
    #1 resetn = 1'b0;
    #1;
    check_eq("t6_haddr", haddr, 32'h0);
    check_eq("t6_hwdata", hwdata, 32'h0);
    check_eq("t6_ctl", {21'b0, htrans, hwrite, busy, grant, req_ready}, 32'h0);
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    push(1, 8'h7A, 1'b1);
    k = 0;
    while (k < 200 && grant == '0) begin
      @(negedge clk);
      k++;
    end
    check_eq("t6_grant", {28'b0, grant}, 32'h2);
    wait_done("t6", 2);
    check_eq("t6_ev0", ev_code[0], RD_TXB);
    check_eq("t6_ev1", ev_code[1], thr(8'h7A));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
